irq_ctrl: RTL and testbench
===========================

// Module: irq_ctrl
// PURPOSE
// - Parametrised core-local trap controller: arbitrates NUM_IRQ external interrupt lines, synchronous exceptions and MRET.
// - Sequences the machine CSR updates, then redirects fetch.
// - Sits beside the decode stage and drives the CSR file write port and the PC-redirect path.
// - New over the single-source controller: per-line edge/level capture with claim pulses, mie gating,
//   fixed priority, illegal-instruction trap, vectored mtvec.
// PARAMETERS
// - NUM_IRQ         8    interrupt lines; 1..16; IRQ_CAUSE_BASE+NUM_IRQ <= 32
// - IRQ_CAUSE_BASE  16   mcause code of line 0; line i -> code BASE+i
// - EDGE_MASK       '0   bit i=1: line i rising-edge captured; 0: level
// PORTS
// - clk_i          in   1        clock
// - rst_i          in   1        synchronous reset, active-high
// - inst_i         in   32       instruction in decode
// - inst_addr_i    in   32       its PC
// - inst_valid_i   in   1        inst_i/inst_addr_i valid this cycle
// - illegal_i      in   1        decode flags inst_i illegal (qualified by inst_valid_i)
// - jump_flag_i    in   1        jump resolving this cycle
// - jump_addr_i    in   32       its target
// - csr_mtvec_i    in   32       mtvec
// - csr_mepc_i     in   32       mepc
// - csr_mstatus_i  in   32       mstatus
// - csr_mie_i      in   32       mie; bit BASE+i enables line i
// - irq_i          in   NUM_IRQ  interrupt request lines
// - irq_claim_o    out  NUM_IRQ  one-hot, one-cycle pulse: line taken
// - csr_wen_o      out  1        CSR write strobe
// - csr_waddr_o    out  32       CSR address, zero-extended 12-bit
// - csr_wdata_o    out  32       CSR write data
// - busy_o         out  1        stall request to pipeline
// - int_flag_o     out  1        one-cycle fetch redirect
// - int_addr_o     out  32       redirect target
// BEHAVIOUR
// - Reset: FSM=IDLE, pending=0, edge history=0; all outputs 0.
//   Reset mid-sequence aborts it: no further CSR writes, no redirect.
// - Pending capture (every cycle, including busy):
//   - Level line: pend[i] = irq_i[i].
//   - Edge line: pend[i] sets on 0->1, clears on its claim; a set in the claim cycle wins.
// - Eligible async: pend[i] & csr_mie_i[BASE+i] & mstatus[3]. Lowest index wins.
// - Decision in IDLE, cycle T, priority order (highest first):
//   1. Sync trap when inst_valid_i: illegal_i cause 2, ECALL 11, EBREAK 3.
//   2. Eligible async: cause {1'b1, BASE+i}.
//   3. MRET when inst_valid_i.
// - busy_o = (decision taken in T) | (FSM != IDLE); combinational.
// - Captured at T:
//   - cause.
//   - epc = inst_addr_i for sync; jump_flag_i ? jump_addr_i : inst_addr_i for async.
//   - Winning index.
// - Trap sequence (registered outputs; wen is high exactly one cycle per write):
//   - T+1: write MEPC (0x341) = epc; irq_claim_o[idx] = 1 if async.
//   - T+2: write MSTATUS (0x300): MPIE(7)=MIE(3), MIE=0, MPP[12:11]=2'b11, other bits kept.
//   - T+3: write MCAUSE (0x342) = cause.
//   - T+4: int_flag_o=1; FSM returns to IDLE.
//     - int_addr_o = {mtvec[31:2],2'b00} when mtvec[1:0]=0, or when sync.
//     - int_addr_o = base + 4*cause[30:0] when mtvec[1:0]=1 and async.
// - MRET sequence:
//   - T+1: write MSTATUS: MIE=MPIE, MPIE=1, MPP=2'b11.
//   - T+2: int_flag_o=1, int_addr_o=csr_mepc_i.
// - States: IDLE, W_MEPC, W_MSTATUS, W_MCAUSE, REDIRECT, W_MRET, MRET_REDIR. Unknown state -> IDLE, outputs 0.
// - No new decision is made while FSM != IDLE. Irqs arriving then stay pending.
//   A level line dropped before IDLE is lost (no claim).
// - Back-to-back: an eligible irq may be taken in the cycle after REDIRECT (re-enable via mstatus.MIE).
// STRUCTURE
// - irq_ctrl_pkg:
//   - state enum.
//   - CSR address constants MSTATUS/MEPC/MCAUSE/MTVEC.
//   - Cause constants: illegal=2, breakpoint=3, ecall=11.
//   - INST_ECALL/EBREAK/MRET encodings.
// - Sub-module irq_prio_enc #(N): req[N-1:0] -> valid, idx, onehot; lowest index wins.
// TESTING
// 1. ECALL at PC 0x100, mtvec 0x8000_0001:
//    - writes MEPC=0x100, MSTATUS MIE 1->0 / MPIE=1, MCAUSE=11.
//    - redirect to 0x8000_0000 at T+4 (sync is never vectored).
// 2. Lines 2 and 5 asserted together, mie bits 18/21 set, MIE=1, mtvec 0x8000_0001:
//    - claim_o=0x04 at T+1.
//    - MCAUSE=0x8000_0012.
//    - int_addr_o=0x8000_0048.
//    - line 5 taken next after MIE re-enabled.
// 3. Edge line 0 (EDGE_MASK=1) pulsed one cycle while busy:
//    - stays pending.
//    - taken after current sequence.
//    - single claim.
// 4. MIE=0 or mie bit clear with irq high -> no busy, no writes. MRET with MPIE=1:
//    - MSTATUS MIE=1.
//    - redirect to csr_mepc_i at T+2.
// 5. Async irq coinciding with jump_flag_i=1, jump_addr_i=0x200:
//    - MEPC=0x200.
//    - Illegal_i and irq together: sync wins, cause 2, irq remains pending.
// 6. rst_i asserted at T+2 of a trap:
//    - next cycle all outputs 0, FSM IDLE.
//    - no MCAUSE write, no redirect.

Source files
------------

// File: rtl/irq_ctrl_pkg.sv
// Shared types and constants for the core-local trap controller.
package irq_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_W_MEPC     = 3'd1,
        S_W_MSTATUS  = 3'd2,
        S_W_MCAUSE   = 3'd3,
        S_REDIRECT   = 3'd4,
        S_W_MRET     = 3'd5,
        S_MRET_REDIR = 3'd6
    } state_e;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;

    localparam logic [31:0] CAUSE_ILLEGAL    = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
    localparam logic [31:0] CAUSE_ECALL      = 32'd11;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
    localparam logic [31:0] INST_MRET   = 32'h3020_0073;

    // Trap entry: stash MIE in MPIE, disable interrupts, record machine mode.
    function automatic logic [31:0] mstatus_trap(input logic [31:0] m);
        logic [31:0] r;
        r        = m;
        r[7]     = m[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] mstatus_mret(input logic [31:0] m);
        logic [31:0] r;
        r        = m;
        r[3]     = m[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module irq_prio_enc #(
    parameter int  N  = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx,
    output logic [N-1:0]  onehot
);

    always_comb begin
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        // Scan downward so the lowest index is the last to overwrite.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid  = 1'b1;
                idx    = IW'(i);
                onehot = N'(1) << i;
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Trap controller: picks sync trap / interrupt / MRET, sequences CSR writes, redirects fetch.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int                 NUM_IRQ        = 8,
    parameter int                 IRQ_CAUSE_BASE = 16,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK      = '0
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [31:0]        inst_i,
    input  logic [31:0]        inst_addr_i,
    input  logic               inst_valid_i,
    input  logic               illegal_i,
    input  logic               jump_flag_i,
    input  logic [31:0]        jump_addr_i,
    input  logic [31:0]        csr_mtvec_i,
    input  logic [31:0]        csr_mepc_i,
    input  logic [31:0]        csr_mstatus_i,
    input  logic [31:0]        csr_mie_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    output logic [NUM_IRQ-1:0] irq_claim_o,
    output logic               csr_wen_o,
    output logic [31:0]        csr_waddr_o,
    output logic [31:0]        csr_wdata_o,
    output logic               busy_o,
    output logic               int_flag_o,
    output logic [31:0]        int_addr_o
);

    localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    state_e             state_q, state_d;
    logic [NUM_IRQ-1:0] hist_q, edge_pend_q, pend, mie_bits, elig, win_oh;
    logic               win_vld;
    logic [IW-1:0]      win_idx;
    logic [31:0]        cause_q, cause_d;
    logic               async_q, async_d;

    logic [NUM_IRQ-1:0] claim_d;
    logic               wen_d, flag_d;
    logic [31:0]        waddr_d, wdata_d, addr_d;

    logic               is_ecall, is_ebreak, is_mret, sync_trap, idle, take;
    logic [31:0]        sync_cause, vec_base, redir_addr;
    logic               unused_mie;

    // Edge lines latch until claimed; level lines follow the pin directly.
    assign pend = (edge_pend_q & EDGE_MASK) | (irq_i & ~EDGE_MASK);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hist_q      <= '0;
            edge_pend_q <= '0;
        end else begin
            hist_q      <= irq_i;
            edge_pend_q <= ((edge_pend_q & ~irq_claim_o) | (irq_i & ~hist_q)) & EDGE_MASK;
        end
    end

    for (genvar g = 0; g < NUM_IRQ; g++) begin : g_mie
        assign mie_bits[g] = csr_mie_i[IRQ_CAUSE_BASE + g];
    end
    assign unused_mie = ^csr_mie_i;

    assign elig = pend & mie_bits & {NUM_IRQ{csr_mstatus_i[3]}};

    irq_prio_enc #(.N(NUM_IRQ)) u_prio (
        .req    (elig),
        .valid  (win_vld),
        .idx    (win_idx),
        .onehot (win_oh)
    );

    assign is_ecall   = inst_valid_i && (inst_i == INST_ECALL);
    assign is_ebreak  = inst_valid_i && (inst_i == INST_EBREAK);
    assign is_mret    = inst_valid_i && (inst_i == INST_MRET);
    assign sync_trap  = (inst_valid_i && illegal_i) || is_ecall || is_ebreak;
    assign sync_cause = illegal_i ? CAUSE_ILLEGAL : (is_ecall ? CAUSE_ECALL : CAUSE_BREAKPOINT);

    assign idle   = (state_q == S_IDLE);
    assign take   = idle && (sync_trap || win_vld || is_mret);
    assign busy_o = take || !idle;

    // Synchronous traps always land on the base, even in vectored mode.
    assign vec_base   = {csr_mtvec_i[31:2], 2'b00};
    assign redir_addr = (csr_mtvec_i[1:0] == 2'b01 && async_q)
                      ? vec_base + {cause_q[29:0], 2'b00} : vec_base;

    always_comb begin
        state_d = state_q;
        cause_d = cause_q;
        async_d = async_q;
        claim_d = '0;
        wen_d   = 1'b0;
        waddr_d = '0;
        wdata_d = '0;
        flag_d  = 1'b0;
        addr_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (sync_trap) begin
                    state_d = S_W_MEPC;
                    cause_d = sync_cause;
                    async_d = 1'b0;
                    wen_d   = 1'b1;
                    waddr_d = {20'd0, CSR_MEPC};
                    wdata_d = inst_addr_i;
                end else if (win_vld) begin
                    state_d = S_W_MEPC;
                    cause_d = {1'b1, 31'(IRQ_CAUSE_BASE) + 31'(win_idx)};
                    async_d = 1'b1;
                    wen_d   = 1'b1;
                    waddr_d = {20'd0, CSR_MEPC};
                    wdata_d = jump_flag_i ? jump_addr_i : inst_addr_i;
                    claim_d = win_oh;
                end else if (is_mret) begin
                    state_d = S_W_MRET;
                    wen_d   = 1'b1;
                    waddr_d = {20'd0, CSR_MSTATUS};
                    wdata_d = mstatus_mret(csr_mstatus_i);
                end
            end
            S_W_MEPC: begin
                state_d = S_W_MSTATUS;
                wen_d   = 1'b1;
                waddr_d = {20'd0, CSR_MSTATUS};
                wdata_d = mstatus_trap(csr_mstatus_i);
            end
            S_W_MSTATUS: begin
                state_d = S_W_MCAUSE;
                wen_d   = 1'b1;
                waddr_d = {20'd0, CSR_MCAUSE};
                wdata_d = cause_q;
            end
            S_W_MCAUSE: begin
                state_d = S_REDIRECT;
                flag_d  = 1'b1;
                addr_d  = redir_addr;
            end
            S_REDIRECT:   state_d = S_IDLE;
            S_W_MRET: begin
                state_d = S_MRET_REDIR;
                flag_d  = 1'b1;
                addr_d  = csr_mepc_i;
            end
            S_MRET_REDIR: state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode, so each shows one cycle after its state is entered.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            cause_q     <= '0;
            async_q     <= 1'b0;
            irq_claim_o <= '0;
            csr_wen_o   <= 1'b0;
            csr_waddr_o <= '0;
            csr_wdata_o <= '0;
            int_flag_o  <= 1'b0;
            int_addr_o  <= '0;
        end else begin
            state_q     <= state_d;
            cause_q     <= cause_d;
            async_q     <= async_d;
            irq_claim_o <= claim_d;
            csr_wen_o   <= wen_d;
            csr_waddr_o <= waddr_d;
            csr_wdata_o <= wdata_d;
            int_flag_o  <= flag_d;
            int_addr_o  <= addr_d;
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: expected CSR writes, claims and redirects are queued with their cycle.
module tb_irq_ctrl;

    localparam int N = 8;
    localparam logic [31:0] ECALL = 32'h0000_0073;
    localparam logic [31:0] MRET  = 32'h3020_0073;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [31:0]   inst_i, inst_addr_i, jump_addr_i;
    logic          inst_valid_i, illegal_i, jump_flag_i;
    logic [31:0]   csr_mtvec_i, csr_mepc_i, csr_mstatus_i, csr_mie_i;
    logic [N-1:0]  irq_i, irq_claim_o;
    logic          csr_wen_o, busy_o, int_flag_o;
    logic [31:0]   csr_waddr_o, csr_wdata_o, int_addr_o;

    irq_ctrl #(.NUM_IRQ(N), .IRQ_CAUSE_BASE(16), .EDGE_MASK(8'h01)) dut (
        .clk_i(clk), .rst_i(rst_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i),
        .inst_valid_i(inst_valid_i), .illegal_i(illegal_i), .jump_flag_i(jump_flag_i),
        .jump_addr_i(jump_addr_i), .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
        .csr_mstatus_i(csr_mstatus_i), .csr_mie_i(csr_mie_i), .irq_i(irq_i),
        .irq_claim_o(irq_claim_o), .csr_wen_o(csr_wen_o), .csr_waddr_o(csr_waddr_o),
        .csr_wdata_o(csr_wdata_o), .busy_o(busy_o), .int_flag_o(int_flag_o),
        .int_addr_o(int_addr_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // kind: 0 = CSR write (a=addr, d=data), 1 = claim (d=onehot), 2 = redirect (d=target)
    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
    } exp_t;
    exp_t sbq[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push(input int c, input int k, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.cyc = c; e.kind = k; e.a = a; e.d = d;
        sbq.push_back(e);
    endtask

    function automatic logic [31:0] trap_ms(input logic [31:0] m);
        return (m & ~32'h0000_1888) | (32'(m[3]) << 7) | 32'h0000_1800;
    endfunction

    function automatic logic [31:0] mret_ms(input logic [31:0] m);
        return (m & ~32'h0000_1888) | (32'(m[7]) << 3) | 32'h0000_1880;
    endfunction

    task automatic exp_trap(input int t, input logic [31:0] epc, input logic [31:0] cause,
                            input logic [31:0] ms, input logic [31:0] tv, input logic [N-1:0] oh);
        logic [31:0] addr;
        push(t + 1, 0, 32'h341, epc);
        if (oh != '0) push(t + 1, 1, 0, 32'(oh));
        push(t + 2, 0, 32'h300, trap_ms(ms));
        push(t + 3, 0, 32'h342, cause);
        addr = {tv[31:2], 2'b00};
        if (tv[1:0] == 2'b01 && cause[31]) addr = addr + {cause[29:0], 2'b00};
        push(t + 4, 2, 0, addr);
    endtask

    task automatic pop_check(input int kind, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        if (sbq.size() == 0) begin
            chk("sb_unexpected", 32'(kind), 32'hFFFF_FFFF);
        end else begin
            e = sbq.pop_front();
            chk("sb_kind", 32'(kind), 32'(e.kind));
            chk("sb_cycle", 32'(cyc), 32'(e.cyc));
            chk("sb_addr", a, e.a);
            chk("sb_data", d, e.d);
        end
    endtask

    always @(negedge clk) begin
        if (csr_wen_o)          pop_check(0, csr_waddr_o, csr_wdata_o);
        if (irq_claim_o != '0)  pop_check(1, 0, 32'(irq_claim_o));
        if (int_flag_o)         pop_check(2, 0, int_addr_o);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_wen"}, 32'(csr_wen_o), 0);
        chk({tag, "_waddr"}, csr_waddr_o, 0);
        chk({tag, "_wdata"}, csr_wdata_o, 0);
        chk({tag, "_flag"}, 32'(int_flag_o), 0);
        chk({tag, "_addr"}, int_addr_o, 0);
        chk({tag, "_claim"}, 32'(irq_claim_o), 0);
        chk({tag, "_busy"}, 32'(busy_o), 0);
    endtask

    int t;

    initial begin
        rst_i = 1'b1; inst_i = '0; inst_addr_i = '0; inst_valid_i = 1'b0; illegal_i = 1'b0;
        jump_flag_i = 1'b0; jump_addr_i = '0; csr_mtvec_i = 32'h8000_0001; csr_mepc_i = 32'h300;
        csr_mstatus_i = '0; csr_mie_i = '0; irq_i = '0;
        run(3);
        #2 chk_quiet("reset");
        rst_i = 1'b0;
        tick();

        // 1: ECALL, vectored mtvec but sync goes to the base
        csr_mstatus_i = 32'h8;
        tick(); inst_valid_i = 1'b1; inst_i = ECALL; inst_addr_i = 32'h100; t = cyc;
        exp_trap(t, 32'h100, 32'd11, 32'h8, csr_mtvec_i, '0);
        #1 chk("t1_busy_T", 32'(busy_o), 1);
        tick(); inst_valid_i = 1'b0; inst_i = '0;
        #1 chk("t1_busy_seq", 32'(busy_o), 1);
        run(6);
        chk("t1_sb_empty", 32'(sbq.size()), 0);
        chk("t1_idle", 32'(busy_o), 0);

        // 2: lines 2 and 5 together; 2 wins, 5 follows back-to-back
        csr_mie_i = (32'd1 << 18) | (32'd1 << 21); inst_addr_i = 32'h400;
        tick(); irq_i = 8'h24; t = cyc;
        exp_trap(t, 32'h400, 32'h8000_0012, 32'h8, csr_mtvec_i, 8'h04);
        #1 chk("t2_busy_T", 32'(busy_o), 1);
        tick(); irq_i = 8'h20;
        run(3);
        tick();
        exp_trap(t + 5, 32'h400, 32'h8000_0015, 32'h8, csr_mtvec_i, 8'h20);
        #1 chk("t2_b2b_busy", 32'(busy_o), 1);
        tick(); irq_i = '0;
        run(6);
        chk("t2_sb_empty", 32'(sbq.size()), 0);

        // 3: edge line 0 pulsed while busy stays pending, one claim
        csr_mie_i = 32'd1 << 16;
        tick(); inst_valid_i = 1'b1; inst_i = ECALL; inst_addr_i = 32'h100; t = cyc;
        exp_trap(t, 32'h100, 32'd11, 32'h8, csr_mtvec_i, '0);
        tick(); inst_valid_i = 1'b0; inst_i = '0; irq_i = 8'h01;
        tick(); irq_i = '0;
        run(2);
        tick();
        exp_trap(t + 5, 32'h100, 32'h8000_0010, 32'h8, csr_mtvec_i, 8'h01);
        #1 chk("t3_pending_busy", 32'(busy_o), 1);
        run(8);
        chk("t3_sb_empty", 32'(sbq.size()), 0);
        chk("t3_idle", 32'(busy_o), 0);

        // 4: masked irqs are ignored; MRET restores MIE
        csr_mstatus_i = 32'h0; csr_mie_i = 32'hFFFF_FFFF; irq_i = 8'h02;
        tick(); #1 chk("t4_mie0_busy", 32'(busy_o), 0);
        tick(); #1 chk("t4_mie0_busy2", 32'(busy_o), 0);
        csr_mstatus_i = 32'h8; csr_mie_i = '0;
        tick(); #1 chk("t4_miebit_busy", 32'(busy_o), 0);
        irq_i = '0; csr_mstatus_i = 32'h80; csr_mepc_i = 32'h300;
        tick(); inst_valid_i = 1'b1; inst_i = MRET; t = cyc;
        push(t + 1, 0, 32'h300, mret_ms(32'h80));
        push(t + 2, 2, 0, 32'h300);
        #1 chk("t4_mret_busy", 32'(busy_o), 1);
        tick(); inst_valid_i = 1'b0; inst_i = '0;
        run(4);
        chk("t4_sb_empty", 32'(sbq.size()), 0);

        // 5: async during a jump takes the jump target; illegal beats irq
        csr_mstatus_i = 32'h8; csr_mie_i = 32'd1 << 19; inst_addr_i = 32'h500;
        tick(); irq_i = 8'h08; jump_flag_i = 1'b1; jump_addr_i = 32'h200; t = cyc;
        exp_trap(t, 32'h200, 32'h8000_0013, 32'h8, csr_mtvec_i, 8'h08);
        tick(); irq_i = '0; jump_flag_i = 1'b0;
        run(6);
        chk("t5a_sb_empty", 32'(sbq.size()), 0);
        tick(); inst_valid_i = 1'b1; illegal_i = 1'b1; inst_addr_i = 32'h600; irq_i = 8'h08; t = cyc;
        exp_trap(t, 32'h600, 32'd2, 32'h8, csr_mtvec_i, '0);
        tick(); inst_valid_i = 1'b0; illegal_i = 1'b0;
        run(3);
        tick();
        exp_trap(t + 5, 32'h600, 32'h8000_0013, 32'h8, csr_mtvec_i, 8'h08);
        #1 chk("t5b_pending_busy", 32'(busy_o), 1);
        tick(); irq_i = '0;
        run(6);
        chk("t5b_sb_empty", 32'(sbq.size()), 0);

        // 6: reset at T+2 aborts the trap
        csr_mie_i = '0;
        tick(); inst_valid_i = 1'b1; inst_i = ECALL; inst_addr_i = 32'h700; t = cyc;
        push(t + 1, 0, 32'h341, 32'h700);
        push(t + 2, 0, 32'h300, trap_ms(32'h8));
        tick(); inst_valid_i = 1'b0; inst_i = '0;
        tick(); rst_i = 1'b1;
        tick(); rst_i = 1'b0;
        #1 chk_quiet("t6_after_rst");
        run(6);
        chk("t6_sb_empty", 32'(sbq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
